// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative multiply and shifts.
// One result per START, reported with a one-cycle DONE pulse.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] hi, hi_n;
    logic [WIDTH-1:0] lo, lo_n;
    logic [WIDTH-1:0] mc, mc_n;
    logic [2:0]       op, op_n;

    logic [WIDTH-1:0] cur_hi, cur_lo, cur_mc;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_hi, mul_lo, sll_v, sra_v;
    logic [WIDTH:0]   add_v, sub_v;
    logic [CNT_W-1:0] shamt;

    logic             fin;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c;

    // The first iteration runs on the START edge, straight from the inputs.
    always_comb begin
        if (state == IDLE) begin
            cur_hi = '0;
            cur_mc = DATA1;
            cur_lo = (SELECT == OP_MUL) ? DATA2 : DATA1;
        end else begin
            cur_hi = hi;
            cur_mc = mc;
            cur_lo = lo;
        end
    end

    assign sum    = {1'b0, cur_hi} + {1'b0, (cur_lo[0] ? cur_mc : '0)};
    assign mul_hi = sum[WIDTH:1];
    assign mul_lo = {sum[0], cur_lo[WIDTH-1:1]};
    assign sll_v  = {cur_lo[WIDTH-2:0], 1'b0};
    assign sra_v  = {cur_lo[WIDTH-1], cur_lo[WIDTH-1:1]};

    assign add_v = {1'b0, DATA1} + {1'b0, DATA2};
    assign sub_v = {1'b0, DATA1} - {1'b0, DATA2};
    assign shamt = (DATA2 > W_VAL) ? W_CNT : CNT_W'(DATA2);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi;
        lo_n    = lo;
        mc_n    = mc;
        op_n    = op;
        fin     = 1'b0;
        fin_res = RESULT;
        fin_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    unique case (SELECT)
                        OP_FWD: begin fin = 1'b1; fin_res = DATA2; end
                        OP_ADD: begin
                            fin = 1'b1;
                            fin_res = add_v[WIDTH-1:0];
                            fin_c = add_v[WIDTH];
                        end
                        OP_AND: begin fin = 1'b1; fin_res = DATA1 & DATA2; end
                        OP_OR:  begin fin = 1'b1; fin_res = DATA1 | DATA2; end
                        OP_SUB: begin
                            fin = 1'b1;
                            fin_res = sub_v[WIDTH-1:0];
                            fin_c = sub_v[WIDTH];
                        end
                        OP_MUL: begin
                            hi_n = mul_hi;
                            lo_n = mul_lo;
                            mc_n = DATA1;
                            op_n = SELECT;
                            cnt_n = W_CNT - 1'b1;
                            state_n = EXEC;
                        end
                        OP_SLL, OP_SRA: begin
                            if (shamt == '0) begin
                                fin = 1'b1;
                                fin_res = DATA1;
                            end else if (shamt == CNT_W'(1)) begin
                                fin = 1'b1;
                                fin_res = (SELECT == OP_SLL) ? sll_v : sra_v;
                                fin_c = (SELECT == OP_SLL) ? DATA1[WIDTH-1] : DATA1[0];
                            end else begin
                                lo_n = (SELECT == OP_SLL) ? sll_v : sra_v;
                                op_n = SELECT;
                                cnt_n = shamt - 1'b1;
                                state_n = EXEC;
                            end
                        end
                    endcase
                end
            end
            EXEC: begin
                cnt_n = cnt - 1'b1;
                if (op == OP_MUL) begin
                    hi_n = mul_hi;
                    lo_n = mul_lo;
                end else begin
                    lo_n = (op == OP_SLL) ? sll_v : sra_v;
                end
                if (cnt == CNT_W'(1)) begin
                    fin = 1'b1;
                    state_n = IDLE;
                    if (op == OP_MUL) begin
                        fin_res = mul_lo;
                        fin_c = |mul_hi;
                    end else if (op == OP_SLL) begin
                        fin_res = sll_v;
                        fin_c = lo[WIDTH-1];
                    end else begin
                        fin_res = sra_v;
                        fin_c = lo[0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mc     <= '0;
            op     <= '0;
            RESULT <= '0;
            ZERO   <= 1'b0;
            CARRY  <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            mc    <= mc_n;
            op    <= op_n;
            DONE  <= fin;
            if (fin) begin
                RESULT <= fin_res;
                ZERO   <= (fin_res == '0);
                CARRY  <= fin_c;
            end
        end
    end

    assign BUSY = (state == EXEC);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table plus multi-cycle,
// back-to-back and mid-operation reset sequences.
module tb_seq_alu;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic [2:0] SELECT = 3'b000;
    logic [7:0] DATA1 = 8'h00;
    logic [7:0] DATA2 = 8'h00;
    logic [7:0] RESULT;
    logic       ZERO, CARRY, BUSY, DONE;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(8), .CNT_W(6)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
        .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] res;
        logic       z;
        logic       c;
        int         lat;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where DONE is seen.
    task automatic run_op(input logic [2:0] sel, input logic [7:0] d1,
                          input logic [7:0] d2, output int lat,
                          output logic busy_bad);
        START = 1'b1;
        SELECT = sel;
        DATA1 = d1;
        DATA2 = d2;
        @(posedge CLK);
        #1;
        START = 1'b0;
        lat = 1;
        busy_bad = 1'b0;
        while (!DONE && lat < 40) begin
            if (!BUSY) busy_bad = 1'b1;
            @(posedge CLK);
            #1;
            lat++;
        end
        if (!DONE) lat = -1;
        if (BUSY) busy_bad = 1'b1;
    endtask

    initial begin
        int   lat;
        logic bb;
        logic bad;

        vt[0]  = '{3'b000, 8'h0F, 8'hF1, 8'hF1, 1'b0, 1'b0, 1};
        vt[1]  = '{3'b001, 8'h0F, 8'hF1, 8'h00, 1'b1, 1'b1, 1};
        vt[2]  = '{3'b010, 8'h0F, 8'hF1, 8'h01, 1'b0, 1'b0, 1};
        vt[3]  = '{3'b011, 8'h0F, 8'hF1, 8'hFF, 1'b0, 1'b0, 1};
        vt[4]  = '{3'b100, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1};
        vt[5]  = '{3'b100, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1};
        vt[6]  = '{3'b101, 8'h12, 8'h0F, 8'h0E, 1'b0, 1'b1, 8};
        vt[7]  = '{3'b111, 8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 3};
        vt[8]  = '{3'b110, 8'h81, 8'hC8, 8'h00, 1'b1, 1'b1, 8};
        vt[9]  = '{3'b110, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1};
        vt[10] = '{3'b111, 8'h81, 8'h01, 8'hC0, 1'b0, 1'b1, 1};
        vt[11] = '{3'b101, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 8};
        vt[12] = '{3'b110, 8'h81, 8'h01, 8'h02, 1'b0, 1'b1, 1};
        vt[13] = '{3'b111, 8'h7F, 8'h09, 8'h00, 1'b1, 1'b0, 8};
        vt[14] = '{3'b110, 8'h03, 8'h02, 8'h0C, 1'b0, 1'b0, 2};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_result", RESULT, 8'h00);
        chk("rst_zero", ZERO, 1'b0);
        chk("rst_carry", CARRY, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("idle_done", DONE, 1'b0);

        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].sel, vt[i].d1, vt[i].d2, lat, bb);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_res", i), RESULT, vt[i].res);
            chk($sformatf("v%0d_zero", i), ZERO, vt[i].z);
            chk($sformatf("v%0d_carry", i), CARRY, vt[i].c);
            chk($sformatf("v%0d_busy", i), bb, 1'b0);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_pulse", i), DONE, 1'b0);
            chk($sformatf("v%0d_hold", i), RESULT, vt[i].res);
        end

        // MULT with a stray ADD request and operand churn while busy
        START = 1'b1;
        SELECT = 3'b101;
        DATA1 = 8'h12;
        DATA2 = 8'h0F;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("mul_busy%0d", k), BUSY, 1'b1);
            chk($sformatf("mul_done%0d", k), DONE, 1'b0);
            chk($sformatf("mul_res%0d", k), RESULT, 8'h0C);
            if (k == 2) begin
                START = 1'b1;
                SELECT = 3'b001;
                DATA1 = 8'h01;
                DATA2 = 8'h02;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK);
            #1;
        end
        chk("mul_done8", DONE, 1'b1);
        chk("mul_busy8", BUSY, 1'b0);
        chk("mul_res8", RESULT, 8'h0E);
        chk("mul_carry8", CARRY, 1'b1);
        @(posedge CLK);
        #1;
        chk("mul_pulse", DONE, 1'b0);
        chk("mul_noadd", RESULT, 8'h0E);

        // Back-to-back: START issued in the DONE cycle
        run_op(3'b001, 8'h10, 8'h20, lat, bb);
        chk("b2b_res1", RESULT, 8'h30);
        run_op(3'b100, 8'h30, 8'h10, lat, bb);
        chk("b2b_lat2", lat, 1);
        chk("b2b_res2", RESULT, 8'h20);
        chk("b2b_carry2", CARRY, 1'b0);

        // Asynchronous reset in the middle of a MULT
        START = 1'b1;
        SELECT = 3'b101;
        DATA1 = 8'h12;
        DATA2 = 8'h0F;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        #3;
        RESET_N = 1'b0;
        #1;
        chk("ar_result", RESULT, 8'h00);
        chk("ar_zero", ZERO, 1'b0);
        chk("ar_carry", CARRY, 1'b0);
        chk("ar_busy", BUSY, 1'b0);
        chk("ar_done", DONE, 1'b0);
        @(posedge CLK);
        #3;
        RESET_N = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) bad = 1'b1;
        end
        chk("ar_quiet", bad, 1'b0);
        run_op(3'b001, 8'h01, 8'h02, lat, bb);
        chk("ar_add_lat", lat, 1);
        chk("ar_add_res", RESULT, 8'h03);
        chk("ar_add_carry", CARRY, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational ALU.
- Adds SUB, iterative multiply and iterative shifts to the existing FORWARD/ADD/AND/OR operations.
- Adds registered RESULT with ZERO/CARRY flags and a START/BUSY/DONE handshake.
- Sits between the register file and the writeback mux; the CPU control unit stalls on BUSY.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 4..32).
- CNT_W, 6, width of the internal step counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET_N  input  1  reset; one clock, asynchronous and active-low.
- START  input  1  request; sampled only when BUSY=0.
- SELECT  input  3  opcode; sampled with START.
- DATA1  input  WIDTH  operand A; sampled with START.
- DATA2  input  WIDTH  operand B or shift count; sampled with START.
- RESULT  output  WIDTH  registered result.
- ZERO  output  1  registered; 1 when RESULT==0.
- CARRY  output  1  registered carry/borrow/overflow/shift-out bit.
- BUSY  output  1  high while a multi-cycle operation is in progress.
- DONE  output  1  single-cycle pulse; RESULT and flags are updated in the same cycle.

Behaviour:
- Reset (RESET_N low, asynchronous): RESULT=0, ZERO=0, CARRY=0, BUSY=0, DONE=0.
  - Also clears the state, counter and operand registers, and aborts any operation in progress.
  - Leaving reset: IDLE, with no spurious DONE.
- Opcodes (arithmetic is modulo 2^WIDTH, unsigned unless noted):
  - 000 FORWARD: RESULT=DATA2, CARRY=0.
  - 001 ADD: RESULT=DATA1+DATA2, CARRY=carry-out.
  - 010 AND: CARRY=0.
  - 011 OR: CARRY=0.
  - 100 SUB: RESULT=DATA1-DATA2, CARRY=1 iff DATA1<DATA2 (borrow).
  - 101 MULT: shift-add, one partial product per cycle. RESULT=low WIDTH bits; CARRY=1 iff any of the high WIDTH bits is nonzero.
  - 110 SLL: DATA1 shifted left by n, one bit per cycle, zero fill.
  - 111 SRA: DATA1 shifted right arithmetic by n, one bit per cycle, sign fill.
  - For SLL/SRA, n=min(DATA2 unsigned, WIDTH). CARRY=last bit shifted out; CARRY=0 when n=0.
- ZERO is always computed from the final RESULT value.
- FSM states:
  - IDLE: BUSY=0.
    - START with opcode 000-100, or a shift with n=0: compute and register RESULT/flags, DONE=1 next cycle, stay in IDLE.
    - START with MULT, or a shift with n>=1: latch operands, load counter (WIDTH for MULT, n for shifts), go to EXEC.
  - EXEC: BUSY=1. One step per cycle, counter decrements. When counter reaches 1, the final step writes RESULT/flags, DONE pulses, BUSY drops, and the FSM returns to IDLE.
- Latency from the START edge at cycle t: DONE asserted at cycle t+L.
  - L=1 for single-cycle operations.
  - L=WIDTH for MULT.
  - L=max(n,1) for shifts.
- DONE stays high for exactly one cycle.
- RESULT and flags hold their value until the next DONE; no intermediate values are visible on RESULT.
- START while BUSY=1 is ignored; operands are not resampled.
- START in the same cycle DONE is high is accepted (FSM is in IDLE), giving back-to-back throughput.
- SELECT/DATA changes during EXEC have no effect; operands are taken from the latched copies.
- Shift count larger than WIDTH is clamped to WIDTH (SLL result 0; SRA result all sign bits).

Test Plan:
- WIDTH=8, DATA1=0x0F, DATA2=0xF1, one START per op, each DONE one cycle after START:
  - FORWARD -> RESULT 0xF1.
  - ADD -> 0x00, ZERO=1, CARRY=1.
  - AND -> 0x01.
  - OR -> 0xFF.
- SUB 0x05-0x07 -> RESULT 0xFE, CARRY=1, ZERO=0. Then SUB 0x07-0x07 -> 0x00, ZERO=1, CARRY=0.
- MULT 0x12*0x0F -> RESULT 0x0E, CARRY=1.
  - DONE exactly 8 cycles after START, BUSY high for cycles t+1..t+7.
  - A second START (ADD) at t+3 is ignored; RESULT never shows the ADD value.
- SRA 0x90 by 3 -> 0xF2, CARRY=0, DONE at t+3.
- SLL 0x81 by 200 (clamped to 8) -> 0x00, ZERO=1, CARRY=1, DONE at t+8.
- SLL by 0 -> RESULT=DATA1, CARRY=0, DONE at t+1.
- Start MULT 0x12*0x0F, pull RESET_N low at t+4 between clock edges:
  - BUSY/DONE/RESULT/flags go to 0 immediately, with no DONE after release.
  - A following ADD 0x01+0x02 -> 0x03 with L=1.
